// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three buses around the memory port arbiter: the instruction
//   fetch request port (if_*), the MEM-stage data port (mem_*), the shared
//   single-ported memory port (ram_*), and the pipeline stall outputs.
//   slave  : arbiter view. It receives IF/MEM requests and the memory
//            response, and drives read data, ready pulses, memory command
//            and stalls.
//   master : environment view (pipeline plus memory), the mirror image.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic        ram_req;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  logic        stall_if;
  logic        stall_mem;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
           ram_rdata, ram_ack,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           ram_req, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch and the MEM
//   stage. Only one requester owns the memory at a time. Each transfer runs
//   IDLE -> BUSY_x -> (wait for ram_ack) -> DONE -> IDLE. MEM normally wins
//   a contested IDLE cycle. After STARVE_MAX consecutive contested MEM
//   grants, IF is forced to win so that fetch keeps making progress.
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset. It abandons any transfer in flight.
//   bus  : mem_port_arbiter_if.slave (IF port, MEM port, memory port, stalls)
// Parameters
//   STARVE_MAX : contested MEM grants allowed before IF must win (>= 1)
module mem_port_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] BUSY_IF  = 2'd1;
  localparam logic [1:0] BUSY_MEM = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_mem;
  logic             grant_if;

  // MEM wins unless IF is also waiting and has already been passed over
  // STARVE_MAX times in a row. These terms only take effect in IDLE.
  always_comb begin
    grant_mem = bus.mem_req & (~bus.if_req | (starve_cnt < STARVE_LIM));
    grant_if  = bus.if_req & ~grant_mem;
  end

  // Stalls are combinational so that the pipeline releases in the same
  // cycle as the ready pulse.
  assign bus.stall_if  = bus.if_req  & ~bus.if_ready;
  assign bus.stall_mem = bus.mem_req & ~bus.mem_ready;

  // The memory command is latched on the grant and held until the ack.
  // The ack is only looked at in BUSY states, so a stray ack after a reset
  // or outside a transfer has no effect. Ready pulses last exactly the
  // DONE cycle. Requests are not sampled in DONE, so a requester that
  // still holds req there is not granted twice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      bus.ram_req   <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.if_rdata  <= '0;
      bus.if_ready  <= 1'b0;
      bus.mem_rdata <= '0;
      bus.mem_ready <= 1'b0;
    end else begin
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem) begin
            state         <= BUSY_MEM;
            bus.ram_req   <= 1'b1;
            bus.ram_we    <= bus.mem_we;
            bus.ram_addr  <= bus.mem_addr;
            bus.ram_wdata <= bus.mem_wdata;
            if (bus.if_req && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else if (grant_if) begin
            state         <= BUSY_IF;
            bus.ram_req   <= 1'b1;
            bus.ram_we    <= 1'b0;
            bus.ram_addr  <= bus.if_addr;
            bus.ram_wdata <= '0;
            starve_cnt    <= '0;
          end
        end
        BUSY_IF: begin
          if (bus.ram_ack) begin
            bus.if_rdata <= bus.ram_rdata;
            bus.if_ready <= 1'b1;
            bus.ram_req  <= 1'b0;
            state        <= DONE;
          end
        end
        BUSY_MEM: begin
          if (bus.ram_ack) begin
            // A write leaves the last read data in place.
            if (!bus.ram_we) begin
              bus.mem_rdata <= bus.ram_rdata;
            end
            bus.mem_ready <= 1'b1;
            bus.ram_req   <= 1'b0;
            state         <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A table of single transfers is
//   applied through applyStimulus and compared through checkOutput.
//   Hand-written sequences follow for contention/starvation, reset
//   mid-transfer, and req held through DONE. A behavioural memory answers
//   ram_req after a programmable number of wait cycles.
module tb_mem_port_arbiter;

  typedef struct {
    logic        isMem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ramRdata;
    int          ackDelay;
    logic [31:0] expRdata;
    int          expLatency;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  int          ackDelay = 0;
  logic [31:0] ramData  = '0;
  logic        forceAck = 1'b0;
  int          busyCnt  = 0;

  int   grantCount     = 0;
  int   ifReadyCount   = 0;
  int   memReadyCount  = 0;
  int   bothReadyCount = 0;
  int   badReqCount    = 0;
  logic prevRamReq     = 1'b0;

  vec_t vecs [5];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory: ack in the (ackDelay+1)-th cycle of ram_req.
  // forceAck drives a stray ack regardless of ram_req.
  always @(posedge clk) begin
    #1;
    if (forceAck) begin
      bus.ram_ack   = 1'b1;
      bus.ram_rdata = 32'hFFFF_FFFF;
      busyCnt       = 0;
    end else if (bus.ram_req) begin
      if (busyCnt == ackDelay) begin
        bus.ram_ack   = 1'b1;
        bus.ram_rdata = ramData;
        busyCnt       = 0;
      end else begin
        bus.ram_ack   = 1'b0;
        bus.ram_rdata = 32'h0;
        busyCnt       = busyCnt + 1;
      end
    end else begin
      bus.ram_ack   = 1'b0;
      bus.ram_rdata = 32'h0;
      busyCnt       = 0;
    end
  end

  // Whole-run monitor: grants, ready pulses, and protocol violations.
  always @(negedge clk) begin
    if (bus.ram_req && !prevRamReq) grantCount = grantCount + 1;
    if (bus.if_ready) ifReadyCount = ifReadyCount + 1;
    if (bus.mem_ready) memReadyCount = memReadyCount + 1;
    if (bus.if_ready && bus.mem_ready) bothReadyCount = bothReadyCount + 1;
    if (!rst && bus.ram_req && (dut.state == 2'd0 || dut.state == 2'd3))
      badReqCount = badReqCount + 1;
    prevRamReq = bus.ram_req;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One complete transfer. req is held through DONE and dropped in the
  // following IDLE cycle. Cycle 0 is the first IDLE cycle with req high.
  task automatic applyStimulus(input string tag, input vec_t v);
    int          lat;
    logic        rdy;
    logic        stl;
    logic [31:0] rd;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        we0;
    logic        stallOk;
    logic        reqOk;
    logic        stableOk;
    @(posedge clk);
    #1;
    ackDelay = v.ackDelay;
    ramData  = v.ramRdata;
    if (v.isMem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = v.we;
      bus.mem_addr  = v.addr;
      bus.mem_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    lat = -1; rd = '0; addr0 = '0; wdata0 = '0; we0 = 1'b0;
    stallOk = 1'b1; reqOk = 1'b1; stableOk = 1'b1;
    for (int c = 0; c < 20 && lat < 0; c++) begin
      @(negedge clk);
      rdy = v.isMem ? bus.mem_ready : bus.if_ready;
      stl = v.isMem ? bus.stall_mem : bus.stall_if;
      if (rdy) begin
        lat = c;
        rd  = v.isMem ? bus.mem_rdata : bus.if_rdata;
        if (stl) stallOk = 1'b0;
        if (bus.ram_req) reqOk = 1'b0;
      end else begin
        if (!stl) stallOk = 1'b0;
        if (c == 0) begin
          if (bus.ram_req) reqOk = 1'b0;
        end else begin
          if (!bus.ram_req) reqOk = 1'b0;
          if (c == 1) begin
            we0 = bus.ram_we; addr0 = bus.ram_addr; wdata0 = bus.ram_wdata;
          end else if (bus.ram_we !== we0 || bus.ram_addr !== addr0 ||
                       bus.ram_wdata !== wdata0) begin
            stableOk = 1'b0;
          end
        end
      end
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(v.expLatency));
    checkOutput({tag, "_ram_addr"}, addr0, v.addr);
    checkOutput({tag, "_ram_we"}, {31'b0, we0}, {31'b0, v.isMem & v.we});
    if (v.isMem && v.we) checkOutput({tag, "_ram_wdata"}, wdata0, v.wdata);
    checkOutput({tag, "_rdata"}, rd, v.expRdata);
    checkOutput({tag, "_stall"}, {31'b0, stallOk}, 32'd1);
    checkOutput({tag, "_ram_req_window"}, {31'b0, reqOk}, 32'd1);
    checkOutput({tag, "_ram_stable"}, {31'b0, stableOk}, 32'd1);
    @(posedge clk);
    #1;
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    @(negedge clk);
    rdy = v.isMem ? bus.mem_ready : bus.if_ready;
    checkOutput({tag, "_ready_pulse_end"}, {31'b0, rdy}, 32'd0);
  endtask

  initial begin
    logic [31:0] grantAddr [6];
    logic [31:0] grantCnt [6];
    logic [31:0] expAddr [6];
    logic [31:0] expCnt [6];
    int          n;
    logic        localPrev;
    logic [31:0] prevCnt;
    logic        badSeen;
    int          g0;
    int          r0;
    int          m0;

    //          isMem we  addr          wdata         ramRdata      dly expRdata      lat
    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0, 32'hDEADBEEF, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h200, 32'h12345678, 32'hBAD0BAD0, 3, 32'h0,        5};
    vecs[2] = '{1'b1, 1'b0, 32'h204, 32'h0,        32'hCAFEF00D, 1, 32'hCAFEF00D, 3};
    vecs[3] = '{1'b1, 1'b1, 32'h208, 32'h0A0A0A0A, 32'h55555555, 0, 32'hCAFEF00D, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,        32'h01234567, 2, 32'h01234567, 4};

    bus.ram_ack   = 1'b0;
    bus.ram_rdata = '0;
    resetDut();
    @(negedge clk);
    checkOutput("init_ram_req", {31'b0, bus.ram_req}, 32'd0);
    checkOutput("init_state", {30'b0, dut.state}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset must clear every registered output, including stale read data.
    resetDut();
    @(negedge clk);
    checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
    checkOutput("rst_mem_rdata", bus.mem_rdata, 32'h0);
    checkOutput("rst_ram_addr", bus.ram_addr, 32'h0);
    checkOutput("rst_ram_wdata", bus.ram_wdata, 32'h0);
    checkOutput("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
    checkOutput("rst_ready", {30'b0, bus.if_ready, bus.mem_ready}, 32'd0);
    checkOutput("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);

    // Contention: both requests held and ack immediate. Order is MEM x4,
    // then IF, then MEM, with the counter seen in IDLE as 0,1,2,3,4,0.
    expAddr = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h400, 32'h300};
    expCnt  = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};
    @(posedge clk);
    #1;
    ackDelay    = 0;
    ramData     = 32'h11110000;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h400;
    bus.mem_req = 1'b1;
    bus.mem_we  = 1'b0;
    bus.mem_addr = 32'h300;
    n = 0;
    localPrev = 1'b0;
    prevCnt = 32'(dut.starve_cnt);
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (bus.ram_req && !localPrev) begin
        grantAddr[n] = bus.ram_addr;
        grantCnt[n]  = prevCnt;
        n = n + 1;
      end
      localPrev = bus.ram_req;
      prevCnt   = 32'(dut.starve_cnt);
    end
    @(posedge clk);
    #1;
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    checkOutput("starve_grant_count", 32'(n), 32'd6);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("starve_grant%0d_addr", i), grantAddr[i], expAddr[i]);
      checkOutput($sformatf("starve_grant%0d_cnt", i), grantCnt[i], expCnt[i]);
    end
    repeat (4) @(negedge clk);

    // Reset while BUSY_MEM waits on a slow ack, then a stray ack arrives.
    resetDut();
    ackDelay     = 3;
    ramData      = 32'h77777777;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstmid_ram_req_busy", {31'b0, bus.ram_req}, 32'd1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.mem_req = 1'b0;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    forceAck = 1'b1;
    badSeen  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) forceAck = 1'b0;
      if (bus.ram_req || bus.mem_ready || dut.state != 2'd0) badSeen = 1'b1;
    end
    forceAck = 1'b0;
    checkOutput("rstmid_ack_ignored", {31'b0, badSeen}, 32'd0);
    checkOutput("rstmid_mem_rdata", bus.mem_rdata, 32'h0);

    // req held through DONE: exactly one grant and one ready pulse.
    resetDut();
    g0 = grantCount;
    r0 = ifReadyCount;
    m0 = memReadyCount;
    applyStimulus("hold", '{1'b0, 1'b0, 32'h180, 32'h0, 32'h0F0F0F0F, 1,
                            32'h0F0F0F0F, 3});
    repeat (4) @(negedge clk);
    checkOutput("hold_grants", 32'(grantCount - g0), 32'd1);
    checkOutput("hold_if_ready", 32'(ifReadyCount - r0), 32'd1);
    checkOutput("hold_mem_ready", 32'(memReadyCount - m0), 32'd0);

    checkOutput("both_ready_never", 32'(bothReadyCount), 32'd0);
    checkOutput("ram_req_idle_done", 32'(badReqCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
